// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Holds the FSM state encoding, opcode field position and the HALT opcode.
package fetch_seq_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_REQ       = 4'd1,
      ST_WAIT_R    = 4'd2,
      ST_LATCH     = 4'd3,
      ST_DECODE    = 4'd4,
      ST_ISSUE     = 4'd5,
      ST_EXEC_WAIT = 4'd6,
      ST_ADVANCE   = 4'd7,
      ST_HALTED    = 4'd8,
      ST_ERROR     = 4'd9
   } state_t;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 28;
   localparam logic [3:0] OPC_HALT = 4'hF;

   // BUSY covers every state that can still make progress
   function automatic logic is_busy(input state_t s);
      case (s)
         ST_IDLE, ST_HALTED, ST_ERROR: is_busy = 1'b0;
         default:                      is_busy = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the sequencer, the fetch stage, instruction memory
// and the execute unit. master = sequencer side.
interface fetch_sequencer_if #(
   parameter int N = 256
) ();
   logic                 MEM_ARVALID;
   logic                 MEM_ARREADY;
   logic                 MEM_RVALID;
   logic                 PC_INCR;
   logic                 INSTR_DONE;
   logic                 EXEC_START;
   logic                 EXEC_DONE;
   logic [$clog2(N)-1:0] PC;
   logic [31:0]          INSTR;

   modport master (
      output MEM_ARVALID, PC_INCR, INSTR_DONE, EXEC_START,
      input  MEM_ARREADY, MEM_RVALID, EXEC_DONE, PC, INSTR
   );

   modport slave (
      input  MEM_ARVALID, PC_INCR, INSTR_DONE, EXEC_START,
      output MEM_ARREADY, MEM_RVALID, EXEC_DONE, PC, INSTR
   );
endinterface

// File: rtl/fetch_sequencer_timeout_counter.sv
// Wait-cycle counter for the memory read response; tc flags the cycle whose
// increment would reach TIMEOUT.
module timeout_counter #(
   parameter int TIMEOUT = 64
) (
   input  logic CLK,
   input  logic RSTN,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count_r;

   assign tc = (count_r == CW'(TIMEOUT - 1));

   // count while enabled, hold once terminal, clear on request
   always_ff @(posedge CLK or posedge RSTN) begin
      if (RSTN) begin
         count_r <= '0;
      end else if (clr) begin
         count_r <= '0;
      end else if (en && !tc) begin
         count_r <= count_r + CW'(1);
      end else begin
         count_r <= count_r;
      end
   end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer FSM: request, wait, latch, decode, issue, execute,
// advance; stops on HALT opcode, last memory word or read timeout.
module fetch_sequencer
   import fetch_seq_pkg::*;
#(
   parameter int N       = 256,
   parameter int TIMEOUT = 64
) (
   input  logic                CLK,
   input  logic                RSTN,
   input  logic                START,
   fetch_sequencer_if.master   bus,
   output logic                BUSY,
   output logic                HALTED,
   output logic                ERROR
);
   localparam int PC_W = $clog2(N);
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(N - 1);

   state_t state_r;
   state_t next_s;
   logic   tc_s;
   logic   cnt_en_s;
   logic   cnt_clr_s;

   assign cnt_en_s  = (state_r == ST_WAIT_R);
   assign cnt_clr_s = (state_r != ST_WAIT_R);

   timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
      .CLK  (CLK),
      .RSTN (RSTN),
      .clr  (cnt_clr_s),
      .en   (cnt_en_s),
      .tc   (tc_s)
   );

   // next-state decode; read data beats timeout in the same cycle
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_IDLE:   if (START) next_s = ST_REQ; else next_s = ST_IDLE;
         ST_REQ:    if (bus.MEM_ARREADY) next_s = ST_WAIT_R; else next_s = ST_REQ;
         ST_WAIT_R: begin
            if (bus.MEM_RVALID)  next_s = ST_LATCH;
            else if (tc_s)       next_s = ST_ERROR;
            else                 next_s = ST_WAIT_R;
         end
         ST_LATCH:  next_s = ST_DECODE;
         ST_DECODE: begin
            if (bus.INSTR[OPC_HI:OPC_LO] == OPC_HALT) next_s = ST_HALTED;
            else                                      next_s = ST_ISSUE;
         end
         ST_ISSUE:  next_s = ST_EXEC_WAIT;
         // the last word halts instead of advancing so the PC never wraps
         ST_EXEC_WAIT: begin
            if (!bus.EXEC_DONE)         next_s = ST_EXEC_WAIT;
            else if (bus.PC == PC_LAST) next_s = ST_HALTED;
            else                        next_s = ST_ADVANCE;
         end
         ST_ADVANCE: next_s = ST_REQ;
         ST_HALTED:  next_s = ST_HALTED;
         ST_ERROR:   next_s = ST_ERROR;
         default:    next_s = ST_ERROR;
      endcase
   end

   // state register with outputs registered from the next state
   always_ff @(posedge CLK or posedge RSTN) begin
      if (RSTN) begin
         state_r         <= ST_IDLE;
         bus.MEM_ARVALID <= 1'b0;
         bus.INSTR_DONE  <= 1'b0;
         bus.EXEC_START  <= 1'b0;
         bus.PC_INCR     <= 1'b0;
         BUSY            <= 1'b0;
         HALTED          <= 1'b0;
         ERROR           <= 1'b0;
      end else begin
         state_r         <= next_s;
         bus.MEM_ARVALID <= (next_s == ST_REQ);
         bus.INSTR_DONE  <= (next_s == ST_LATCH);
         bus.EXEC_START  <= (next_s == ST_ISSUE);
         bus.PC_INCR     <= (next_s == ST_ADVANCE);
         BUSY            <= is_busy(next_s);
         HALTED          <= (next_s == ST_HALTED);
         ERROR           <= (next_s == ST_ERROR);
      end
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a fetch-stage, memory and execute
// model; N=4 so the end-of-memory case shares the same instance.
module tb_fetch_sequencer;
   localparam int N       = 4;
   localparam int TIMEOUT = 64;

   logic CLK = 1'b0;
   logic RSTN = 1'b0;
   logic START = 1'b0;
   logic BUSY, HALTED, ERROR;

   fetch_sequencer_if #(.N(N)) bus ();

   fetch_sequencer #(.N(N), .TIMEOUT(TIMEOUT)) dut (
      .CLK    (CLK),
      .RSTN   (RSTN),
      .START  (START),
      .bus    (bus),
      .BUSY   (BUSY),
      .HALTED (HALTED),
      .ERROR  (ERROR)
   );

   always #5 CLK = ~CLK;

   logic [31:0] mem [0:N-1];
   int ar_delay, r_delay, ex_delay;
   int checks = 0;
   int errors = 0;

   int ar_cnt, r_cnt, ex_cnt;
   bit ar_hs, r_wait, ex_wait;
   int cyc, n_arv, n_idone, n_exec, n_incr, n_overlap;
   int first_arv, incr_cyc, wait_cyc, err_cyc;
   int idone_cyc [0:3];

   // fetch stage: PC and instruction registers
   always @(posedge CLK or posedge RSTN) begin
      if (RSTN) begin
         bus.PC    <= '0;
         bus.INSTR <= 32'd0;
      end else begin
         if (bus.PC_INCR)    bus.PC    <= bus.PC + 2'd1;
         if (bus.INSTR_DONE) bus.INSTR <= mem[bus.PC];
      end
   end

   // memory / execute responder and pulse monitor, all on the falling edge
   initial begin
      bus.MEM_ARREADY = 1'b0;
      bus.MEM_RVALID  = 1'b0;
      bus.EXEC_DONE   = 1'b0;
      forever begin
         @(negedge CLK);
         if (RSTN) begin
            bus.MEM_ARREADY = 1'b0; bus.MEM_RVALID = 1'b0; bus.EXEC_DONE = 1'b0;
            ar_cnt = 0; r_cnt = 0; ex_cnt = 0; ar_hs = 1'b0; r_wait = 1'b0; ex_wait = 1'b0;
            cyc = 0; n_arv = 0; n_idone = 0; n_exec = 0; n_incr = 0; n_overlap = 0;
            first_arv = -1; incr_cyc = -1; wait_cyc = -1; err_cyc = -1;
         end else begin
            cyc++;
            if (bus.MEM_ARVALID) begin
               if (first_arv < 0) first_arv = cyc;
               n_arv++;
            end
            if (bus.INSTR_DONE) begin
               if (n_idone < 4) idone_cyc[n_idone] = cyc;
               n_idone++;
            end
            if (bus.EXEC_START) n_exec++;
            if (bus.PC_INCR) begin
               if (incr_cyc < 0) incr_cyc = cyc;
               n_incr++;
            end
            if ((32'(bus.INSTR_DONE) + 32'(bus.EXEC_START) + 32'(bus.PC_INCR)) > 1) n_overlap++;
            if (ERROR && err_cyc < 0) err_cyc = cyc;

            if (bus.MEM_RVALID) begin bus.MEM_RVALID = 1'b0; r_wait = 1'b0; end
            if (bus.EXEC_DONE)  begin bus.EXEC_DONE = 1'b0;  ex_wait = 1'b0; end
            if (ar_hs) begin
               ar_hs = 1'b0; bus.MEM_ARREADY = 1'b0; ar_cnt = 0;
               r_wait = 1'b1; r_cnt = 0; wait_cyc = cyc;
            end else if (bus.MEM_ARVALID) begin
               bus.MEM_ARREADY = (ar_cnt == ar_delay);
               ar_hs = bus.MEM_ARREADY;
               ar_cnt++;
            end else begin
               ar_cnt = 0;
            end
            if (r_wait) begin
               bus.MEM_RVALID = (r_cnt == r_delay);
               r_cnt++;
            end
            if (ex_wait) begin
               bus.EXEC_DONE = (ex_cnt == ex_delay);
               ex_cnt++;
            end else if (bus.EXEC_START) begin
               ex_wait = 1'b1; ex_cnt = 0;
            end
         end
      end
   end

   task automatic do_reset(input int ard, input int rd, input int exd);
      ar_delay = ard; r_delay = rd; ex_delay = exd;
      RSTN = 1'b1; START = 1'b0;
      @(negedge CLK); @(negedge CLK); #1;
      RSTN = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge CLK); START = 1'b1;
      @(negedge CLK); START = 1'b0; #1;
   endtask

   // sel 0: terminal state, 1: first PC_INCR, 2: 5 cycles into WAIT_R, 3: first EXEC_START
   task automatic wait_for(input int sel, input int max, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < max && !ok; k++) begin
         case (sel)
            0: ok = HALTED || ERROR;
            1: ok = n_incr >= 1;
            2: ok = (wait_cyc >= 0) && (cyc >= wait_cyc + 5);
            default: ok = n_exec >= 1;
         endcase
         if (!ok) begin @(negedge CLK); #1; end
      end
   endtask

   task automatic test_reset();
      bit ok;
      RSTN = 1'b0; #1; RSTN = 1'b1; #1;
      checks++;
      if ({bus.MEM_ARVALID, bus.INSTR_DONE, bus.EXEC_START, bus.PC_INCR, BUSY, HALTED, ERROR} !== 7'b0) begin
         errors++; $display("FAIL reset_outputs: got %b expected 0000000",
            {bus.MEM_ARVALID, bus.INSTR_DONE, bus.EXEC_START, bus.PC_INCR, BUSY, HALTED, ERROR});
      end
      mem[0] = 32'hF000_0000; mem[1] = 32'h0; mem[2] = 32'h0; mem[3] = 32'h0;
      do_reset(0, -1, 0);
      pulse_start();
      wait_for(2, 40, ok);
      checks++;
      if (!ok || BUSY !== 1'b1) begin errors++; $display("FAIL wait_r_busy: ok %0d BUSY %b expected 1", ok, BUSY); end
      #2 RSTN = 1'b1; #1;
      checks++;
      if ({bus.MEM_ARVALID, bus.INSTR_DONE, bus.EXEC_START, bus.PC_INCR, BUSY, HALTED, ERROR} !== 7'b0) begin
         errors++; $display("FAIL async_reset: got %b expected 0000000",
            {bus.MEM_ARVALID, bus.INSTR_DONE, bus.EXEC_START, bus.PC_INCR, BUSY, HALTED, ERROR});
      end
      @(negedge CLK); #1 RSTN = 1'b0;
      r_delay = 0;
      pulse_start();
      checks++;
      if (bus.MEM_ARVALID !== 1'b1 || BUSY !== 1'b1 || n_idone != 0) begin
         errors++; $display("FAIL restart_req: ARVALID %b BUSY %b idone %0d expected 1 1 0", bus.MEM_ARVALID, BUSY, n_idone);
      end
      wait_for(0, 40, ok);
      checks++;
      if (!ok || HALTED !== 1'b1) begin errors++; $display("FAIL restart_halt: HALTED %b expected 1", HALTED); end
   endtask

   task automatic test_normal();
      bit ok;
      mem[0] = 32'h1000_0001; mem[1] = 32'h2000_0002; mem[2] = 32'hF000_0000; mem[3] = 32'h0;
      do_reset(0, 0, 0);
      pulse_start();
      wait_for(0, 100, ok);
      checks++;
      if (!ok || HALTED !== 1'b1 || ERROR !== 1'b0 || BUSY !== 1'b0) begin
         errors++; $display("FAIL normal_halt: H %b E %b B %b expected 1 0 0", HALTED, ERROR, BUSY);
      end
      checks++;
      if (bus.PC !== 2'd2) begin errors++; $display("FAIL normal_pc: got %0d expected 2", bus.PC); end
      checks++;
      if (n_exec != 2 || n_idone != 3 || n_incr != 2) begin
         errors++; $display("FAIL normal_pulses: exec %0d idone %0d incr %0d expected 2 3 2", n_exec, n_idone, n_incr);
      end
      checks++;
      if (idone_cyc[1] - idone_cyc[0] != 7 || idone_cyc[2] - idone_cyc[1] != 7) begin
         errors++; $display("FAIL normal_period: got %0d %0d expected 7 7",
            idone_cyc[1] - idone_cyc[0], idone_cyc[2] - idone_cyc[1]);
      end
      checks++;
      if (n_overlap != 0) begin errors++; $display("FAIL pulse_exclusive: got %0d expected 0", n_overlap); end
   endtask

   task automatic test_back_pressure();
      bit ok;
      mem[0] = 32'h3000_0003; mem[1] = 32'hF000_0000; mem[2] = 32'h0; mem[3] = 32'h0;
      do_reset(3, 10, 4);
      pulse_start();
      wait_for(1, 100, ok);
      checks++;
      if (!ok || n_arv != 4) begin errors++; $display("FAIL bp_arvalid: got %0d cycles expected 4", n_arv); end
      checks++;
      if (n_idone != 1 || n_incr != 1 || n_exec != 1 || ERROR !== 1'b0) begin
         errors++; $display("FAIL bp_pulses: idone %0d incr %0d exec %0d err %b expected 1 1 1 0",
            n_idone, n_incr, n_exec, ERROR);
      end
      checks++;
      if (incr_cyc - first_arv != 23) begin errors++; $display("FAIL bp_latency: got %0d expected 23", incr_cyc - first_arv); end
   endtask

   task automatic test_timeout();
      bit ok;
      do_reset(0, -1, 0);
      pulse_start();
      wait_for(0, 200, ok);
      checks++;
      if (!ok || ERROR !== 1'b1 || HALTED !== 1'b0 || BUSY !== 1'b0) begin
         errors++; $display("FAIL timeout_state: E %b H %b B %b expected 1 0 0", ERROR, HALTED, BUSY);
      end
      checks++;
      if (err_cyc - wait_cyc != 64) begin errors++; $display("FAIL timeout_cycles: got %0d expected 64", err_cyc - wait_cyc); end
      checks++;
      if (n_idone != 0) begin errors++; $display("FAIL timeout_idone: got %0d expected 0", n_idone); end
   endtask

   task automatic test_timeout_boundary();
      bit ok;
      mem[0] = 32'hF000_0000;
      do_reset(0, 63, 0);
      pulse_start();
      wait_for(0, 200, ok);
      checks++;
      if (!ok || HALTED !== 1'b1 || ERROR !== 1'b0) begin
         errors++; $display("FAIL boundary_state: H %b E %b expected 1 0", HALTED, ERROR);
      end
      checks++;
      if (n_idone != 1 || bus.PC !== 2'd0) begin
         errors++; $display("FAIL boundary_latch: idone %0d pc %0d expected 1 0", n_idone, bus.PC);
      end
   endtask

   task automatic test_end_of_mem();
      bit ok;
      for (int i = 0; i < N; i++) mem[i] = 32'h1000_0000 + 32'(i);
      do_reset(0, 0, 0);
      pulse_start();
      wait_for(0, 100, ok);
      checks++;
      if (!ok || HALTED !== 1'b1 || ERROR !== 1'b0) begin
         errors++; $display("FAIL eom_state: H %b E %b expected 1 0", HALTED, ERROR);
      end
      checks++;
      if (n_exec != 4 || n_incr != 3 || n_idone != 4) begin
         errors++; $display("FAIL eom_pulses: exec %0d incr %0d idone %0d expected 4 3 4", n_exec, n_incr, n_idone);
      end
      repeat (5) @(negedge CLK);
      #1;
      checks++;
      if (bus.PC !== 2'd3) begin errors++; $display("FAIL eom_pc: got %0d expected 3", bus.PC); end
   endtask

   task automatic test_start_ignored();
      bit ok;
      int arv_before;
      mem[0] = 32'h4000_0004; mem[1] = 32'hF000_0000; mem[2] = 32'h0; mem[3] = 32'h0;
      do_reset(0, 0, 6);
      pulse_start();
      wait_for(3, 50, ok);
      @(negedge CLK); #1;
      START = 1'b1;
      @(negedge CLK); #1;
      START = 1'b0;
      wait_for(0, 100, ok);
      checks++;
      if (!ok || HALTED !== 1'b1 || n_exec != 1 || n_idone != 2 || n_arv != 2 || bus.PC !== 2'd1) begin
         errors++; $display("FAIL start_exec_wait: H %b exec %0d idone %0d arv %0d pc %0d expected 1 1 2 2 1",
            HALTED, n_exec, n_idone, n_arv, bus.PC);
      end
      arv_before = n_arv;
      pulse_start();
      repeat (5) @(negedge CLK);
      #1;
      checks++;
      if (n_arv != arv_before || HALTED !== 1'b1 || BUSY !== 1'b0) begin
         errors++; $display("FAIL start_halted: arv %0d H %b B %b expected %0d 1 0", n_arv, HALTED, BUSY, arv_before);
      end
   endtask

   initial begin
      ar_delay = 0; r_delay = 0; ex_delay = 0;
      test_reset();
      test_normal();
      test_back_pressure();
      test_timeout();
      test_timeout_boundary();
      test_end_of_mem();
      test_start_ignored();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- FSM controller that sequences the instruction-fetch stage: issues memory reads at the current PC, commands the fetch stage to latch the returned word, and hands the instruction to the execute stage.
- On completion it advances the PC.
- Sits between the fetch stage (drives its PC_INCR/INSTR_DONE), the AXI-side instruction memory read handshake and the execute/control unit.
- Detects HALT opcode, end of program memory and memory-response timeout.

Parameters:
- N, 256, instruction memory depth in words; PC width = $clog2(N).
- TIMEOUT, 64, max cycles in WAIT_R before error; counter width $clog2(TIMEOUT+1).

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  reset, asynchronous, active-high (asserted = 1), despite the name.
- START  in  1  begin execution; sampled only in IDLE.
- PC  in  $clog2(N)  current PC from fetch stage.
- INSTR  in  32  latched instruction from fetch stage.
- MEM_ARVALID  out  1  read request to instruction memory at PC.
- MEM_ARREADY  in  1  memory accepts request.
- MEM_RVALID  in  1  read data valid on memory data bus.
- PC_INCR  out  1  one-cycle pulse: fetch stage PC += 1.
- INSTR_DONE  out  1  one-cycle pulse: fetch stage latches memory data.
- EXEC_START  out  1  one-cycle pulse: execute INSTR.
- EXEC_DONE  in  1  execute stage finished.
- BUSY  out  1  high in any state except IDLE/HALTED/ERROR.
- HALTED  out  1  sticky, program ended.
- ERROR  out  1  sticky, memory timeout.

Behaviour:
- Reset (async, RSTN=1): state IDLE, timeout counter 0, all outputs 0 immediately; mid-operation reset abandons any outstanding request with no further pulses.
- All outputs registered or decoded from state only; no combinational input-to-output paths.
- States: IDLE, REQ, WAIT_R, LATCH, DECODE, ISSUE, EXEC_WAIT, ADVANCE, HALTED, ERROR.
- IDLE: START=1 -> REQ; START ignored in all other states.
- REQ: MEM_ARVALID=1, held until MEM_ARREADY=1 in the same cycle -> WAIT_R, counter cleared. No timeout in REQ.
- WAIT_R: counter increments each cycle.
  - MEM_RVALID=1 -> LATCH.
  - Else counter reaching TIMEOUT -> ERROR.
  - MEM_RVALID wins if both occur in the same cycle.
  - MEM_RVALID is ignored in all other states.
- LATCH: INSTR_DONE=1 for exactly one cycle -> DECODE. The fetch stage's INSTR register updates at the end of this cycle.
- DECODE: inspect INSTR[31:28].
  - Equal to OPC_HALT (4'hF) -> HALTED. PC not incremented.
  - Else -> ISSUE.
- ISSUE: EXEC_START=1 for one cycle -> EXEC_WAIT. EXEC_DONE is not sampled in ISSUE.
- EXEC_WAIT: EXEC_DONE=1 -> ADVANCE.
  - If PC == N-1, -> HALTED instead, with no PC_INCR, so the PC never wraps.
- ADVANCE: PC_INCR=1 for one cycle -> REQ. The PC update is visible in REQ on the next cycle.
- HALTED, ERROR: terminal, exited only by reset. HALTED=1 / ERROR=1 respectively, BUSY=0.
- Minimum latency per instruction (ARREADY and RVALID each in first cycle, EXEC_DONE in first cycle of EXEC_WAIT): REQ, WAIT_R, LATCH, DECODE, ISSUE, EXEC_WAIT, ADVANCE = 7 cycles.
- Exactly one PC_INCR, one INSTR_DONE and one EXEC_START per non-halt instruction; the PC_INCR/INSTR_DONE/EXEC_START pulses are mutually exclusive.

Decomposition:
- Package fetch_seq_pkg holds:
  - state_t enum (10 states above);
  - OPC_HI=31, OPC_LO=28;
  - OPC_HALT=4'hF.
- One natural sub-module: timeout_counter (clear, enable, terminal-count flag, parameter TIMEOUT).
- The FSM stays in fetch_sequencer.

Test Plan:
- Reset during WAIT_R (after 5 wait cycles): RSTN pulsed asynchronously -> all outputs 0 without a clock edge; after release, START restarts the sequence from REQ.
- Normal program: memory words 0x1000_0001, 0x2000_0002, 0xF000_0000, ARREADY/RVALID/EXEC_DONE immediate:
  - 7-cycle instruction period;
  - PC 0->1->2;
  - EXEC_START twice, INSTR_DONE 3 times, PC_INCR twice;
  - HALTED=1 with PC=2.
- Back-pressure: ARREADY low 3 cycles, RVALID after 10 cycles, EXEC_DONE after 4 -> ARVALID held 4 cycles, single INSTR_DONE, single PC_INCR, ERROR=0.
- Timeout, TIMEOUT=64: RVALID never asserted -> ERROR=1 exactly 64 cycles after entering WAIT_R, BUSY=0, no INSTR_DONE.
- Timeout boundary: RVALID on the same cycle the counter hits 64 -> LATCH taken, ERROR stays 0.
- End of memory, N=4: non-halt instructions at all 4 addresses -> 4 EXEC_STARTs, 3 PC_INCRs, HALTED=1 with PC=3, no wrap to 0.
- START pulsed during EXEC_WAIT and in HALTED -> no effect.
